// File: rtl/lgn_frame_ctrl.sv
// lgn_frame_ctrl: byte-stream frame controller around a logic network with popcount/argmax/raw result streaming
module lgn_frame_ctrl #(
  parameter int INPUT_BITS  = 400,
  parameter int OUTPUT_BITS = 50,
  parameter int NUM_CLASSES = 10,
  parameter int NET_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic [1:0]             mode,
  output logic [INPUT_BITS-1:0]  net_x,
  input  logic [OUTPUT_BITS-1:0] net_y,
  output logic [7:0]             tx_data,
  output logic                   tx_dv,
  input  logic                   tx_active,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);
  localparam int NB = INPUT_BITS / 8;
  localparam int G  = OUTPUT_BITS / NUM_CLASSES;
  localparam int CW = $clog2(G + 1);
  localparam int BW = $clog2(NB + 1);
  localparam int KW = $clog2(NUM_CLASSES + 1);
  localparam int LW = $clog2(NET_LATENCY + 1);
  typedef enum logic [1:0] {RECV, WAIT, SCORE, SEND} state_t;
  state_t                 state_q, state_d;
  logic [INPUT_BITS-1:0]  net_x_q, net_x_d;
  logic [BW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [LW-1:0]          lat_q, lat_d;
  logic [OUTPUT_BITS-1:0] y_q, y_d;
  logic [KW-1:0]          k_q, k_d, idx_q, idx_d, max_idx_q, max_idx_d;
  logic [CW-1:0]          max_val_q, max_val_d, pc;
  logic [CW-1:0]          cnt_q [NUM_CLASSES];
  logic [CW-1:0]          cnt_d [NUM_CLASSES];
  logic [1:0]             mode_q, mode_d;
  logic                   pend_q, pend_d, tx_dv_q, tx_dv_d, fd_q, fd_d, ovr_q, ovr_d;
  logic [7:0]             tx_data_q, tx_data_d, res;
  logic [G-1:0]           grp;
  logic                   last_byte;
  always_comb begin
    grp = '0;
    res = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (KW'(i) == k_q) grp = y_q[i*G +: G];
      if (KW'(i) == idx_q) res = mode_q == 2'd2 ? 8'(y_q[i*G +: G]) : 8'(cnt_q[i]);
    end
    if (mode_q == 2'd1) res = 8'(max_idx_q);
    pc = '0;
    for (int i = 0; i < G; i++) pc = pc + CW'(grp[i]);
    last_byte = idx_q == (mode_q == 2'd1 ? KW'(0) : KW'(NUM_CLASSES - 1));
  end
  always_comb begin
    state_d   = state_q;
    net_x_d   = net_x_q;
    rx_cnt_d  = rx_cnt_q;
    lat_d     = lat_q;
    y_d       = y_q;
    k_d       = k_q;
    idx_d     = idx_q;
    max_idx_d = max_idx_q;
    max_val_d = max_val_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    pend_d    = pend_q;
    tx_dv_d   = 1'b0;
    tx_data_d = tx_data_q;
    fd_d      = 1'b0;
    ovr_d     = ovr_q | (rx_valid && state_q != RECV);
    case (state_q)
      RECV: if (rx_valid) begin
        for (int i = 0; i < NB; i++)
          if (BW'(i) == rx_cnt_q) net_x_d[INPUT_BITS-1-8*i -: 8] = rx_data;
        if (rx_cnt_q == '0) mode_d = mode == 2'd3 ? 2'd0 : mode;
        rx_cnt_d = rx_cnt_q == BW'(NB - 1) ? '0 : rx_cnt_q + 1'b1;
        state_d  = rx_cnt_q == BW'(NB - 1) ? WAIT : RECV;
      end
      WAIT: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LW'(NET_LATENCY)) begin
          lat_d     = '0;
          y_d       = net_y;
          k_d       = '0;
          max_val_d = '0;
          max_idx_d = '0;
          state_d   = SCORE;
        end
      end
      SCORE: begin
        for (int i = 0; i < NUM_CLASSES; i++)
          if (KW'(i) == k_q) cnt_d[i] = pc;
        if (pc > max_val_q) begin
          max_val_d = pc;
          max_idx_d = k_q;
        end
        k_d     = k_q == KW'(NUM_CLASSES - 1) ? '0 : k_q + 1'b1;
        state_d = k_q == KW'(NUM_CLASSES - 1) ? SEND : SCORE;
      end
      default: if (pend_q) begin
        if (tx_done) begin
          pend_d  = 1'b0;
          idx_d   = last_byte ? '0 : idx_q + 1'b1;
          fd_d    = last_byte;
          state_d = last_byte ? RECV : SEND;
        end
      end else if (!tx_active) begin
        tx_dv_d   = 1'b1;
        tx_data_d = res;
        pend_d    = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RECV;
      net_x_q   <= '0;
      rx_cnt_q  <= '0;
      lat_q     <= '0;
      y_q       <= '0;
      k_q       <= '0;
      idx_q     <= '0;
      max_idx_q <= '0;
      max_val_q <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
      mode_q    <= '0;
      pend_q    <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_data_q <= '0;
      fd_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      net_x_q   <= net_x_d;
      rx_cnt_q  <= rx_cnt_d;
      lat_q     <= lat_d;
      y_q       <= y_d;
      k_q       <= k_d;
      idx_q     <= idx_d;
      max_idx_q <= max_idx_d;
      max_val_q <= max_val_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      pend_q    <= pend_d;
      tx_dv_q   <= tx_dv_d;
      tx_data_q <= tx_data_d;
      fd_q      <= fd_d;
      ovr_q     <= ovr_d;
    end
  end
  assign net_x      = net_x_q;
  assign tx_data    = tx_data_q;
  assign tx_dv      = tx_dv_q;
  assign busy       = state_q != RECV;
  assign frame_done = fd_q;
  assign overrun    = ovr_q;
endmodule
